// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes, lamp encodings and phase width shared by the traffic phase controller
package traffic_pkg;
  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] RED_A = 3'd0;
  localparam logic [PHASE_W-1:0] NS_G  = 3'd1;
  localparam logic [PHASE_W-1:0] NS_Y  = 3'd2;
  localparam logic [PHASE_W-1:0] RED_B = 3'd3;
  localparam logic [PHASE_W-1:0] EW_G  = 3'd4;
  localparam logic [PHASE_W-1:0] EW_Y  = 3'd5;
  localparam logic [PHASE_W-1:0] WALK  = 3'd6;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
endpackage

// File: rtl/tl_countdown.sv
// tl_countdown: tick-driven down counter (clk, reset async low, tick, load/load_val -> cnt_q, zero); load wins over tick and saturates at 0
module tl_countdown #(
  parameter int NBITS = 16,
  parameter logic [NBITS-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  output logic [NBITS-1:0] cnt_q,
  output logic             zero
);
  logic [NBITS-1:0] cnt_d;
  always_comb cnt_d = load ? load_val : (tick && !zero) ? cnt_q - NBITS'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: four-way phase sequencer with rest-in-green (clk, reset async low, tick, car_ns, car_ew -> ns_light, ew_light, phase, cnt_q; ped_req/walk when TRAFFIC_PED_WALK_EN is defined)
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NBITS    = 16,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 4,
  parameter int T_RED    = 2,
  parameter int T_WALK   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               car_ns,
  input  logic               car_ew,
`ifdef TRAFFIC_PED_WALK_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic [PHASE_W-1:0] phase,
  output logic [NBITS-1:0]   cnt_q
);
  localparam longint LIM = longint'(1) << NBITS;
  localparam logic [NBITS-1:0] LD_G = NBITS'(T_GREEN) - NBITS'(1);
  localparam logic [NBITS-1:0] LD_Y = NBITS'(T_YELLOW) - NBITS'(1);
  localparam logic [NBITS-1:0] LD_R = NBITS'(T_RED) - NBITS'(1);
  if (T_GREEN < 1 || T_GREEN >= LIM || T_YELLOW < 1 || T_YELLOW >= LIM ||
      T_RED < 1 || T_RED >= LIM || T_WALK < 1 || T_WALK >= LIM) begin : g_cfg_err
    $error("traffic_phase_ctrl: timing parameter outside 1..2^NBITS-1");
  end
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               load, zero, expire, go_walk;
  logic [NBITS-1:0]   load_val, ld_other;
  assign expire = tick && zero;
`ifdef TRAFFIC_PED_WALK_EN
  localparam logic [NBITS-1:0] LD_W = NBITS'(T_WALK) - NBITS'(1);
  logic ped_pend_q, ped_pend_d;
  assign go_walk  = ped_pend_q;
  assign ld_other = phase_d == WALK ? LD_W : LD_R;
  always_comb ped_pend_d = ped_req | (ped_pend_q & ~(phase_d == WALK && phase_q != WALK));
  always_ff @(posedge clk or negedge reset)
    if (!reset) ped_pend_q <= 1'b0;
    else ped_pend_q <= ped_pend_d;
`else
  assign go_walk  = 1'b0;
  assign ld_other = LD_R;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) phase_q <= RED_A;
    else phase_q <= phase_d;
  // Greens only move on when the crossing approach has demand; holding without a load keeps cnt_q at 0.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      RED_A: phase_d = expire ? (go_walk ? WALK : NS_G) : phase_q;
      NS_G:  phase_d = (expire && car_ew) ? NS_Y : phase_q;
      NS_Y:  phase_d = expire ? RED_B : phase_q;
      RED_B: phase_d = expire ? EW_G : phase_q;
      EW_G:  phase_d = (expire && car_ns) ? EW_Y : phase_q;
      EW_Y:  phase_d = expire ? RED_A : phase_q;
`ifdef TRAFFIC_PED_WALK_EN
      WALK:  phase_d = expire ? NS_G : phase_q;
`endif
      default: phase_d = RED_A;
    endcase
    load     = phase_d != phase_q;
    load_val = (phase_d == NS_G || phase_d == EW_G) ? LD_G :
               (phase_d == NS_Y || phase_d == EW_Y) ? LD_Y : ld_other;
  end
  tl_countdown #(.NBITS(NBITS), .RST_VAL(LD_R)) u_cnt (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_val(load_val), .cnt_q(cnt_q), .zero(zero)
  );
  always_comb begin
    phase    = phase_q;
    ns_light = phase_q == NS_G ? LAMP_G : phase_q == NS_Y ? LAMP_Y : LAMP_R;
    ew_light = phase_q == EW_G ? LAMP_G : phase_q == EW_Y ? LAMP_Y : LAMP_R;
`ifdef TRAFFIC_PED_WALK_EN
    walk     = phase_q == WALK;
`endif
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: randomized self-checking bench against a phase/duration table model
module tb_traffic_phase_ctrl;
  localparam int NB = 16;
  logic clk = 0, reset = 0, tick = 1, car_ns = 1, car_ew = 1, ped_req = 0;
  logic [2:0] ns_light, ew_light, phase;
  logic [NB-1:0] cnt_q;
`ifdef TRAFFIC_PED_WALK_EN
  logic walk;
`endif
  int n_cmp = 0, n_bad = 0;
  int m_ph, m_cnt;
  bit m_ped;
  traffic_phase_ctrl #(.NBITS(NB), .T_GREEN(3), .T_YELLOW(2), .T_RED(1), .T_WALK(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .car_ns(car_ns), .car_ew(car_ew),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase), .cnt_q(cnt_q)
  );
  always #5 clk = ~clk;
  function automatic int dur(int p);
    case (p)
      1, 4: return 3;
      2, 5, 6: return 2;
      default: return 1;
    endcase
  endfunction
  function automatic logic [5:0] lamps(int p);
    case (p)
      1: return 6'b001_100;
      2: return 6'b010_100;
      4: return 6'b100_001;
      5: return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction
  function automatic logic [NB+8:0] model_vec();
    return {3'(m_ph), NB'(m_cnt), lamps(m_ph)};
  endfunction
  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_ped = 0;
  endtask
  task automatic step();
    int nxt;
    bit entered;
    @(posedge clk);
    entered = 0;
    if (tick) begin
      if (m_cnt > 0) m_cnt--;
      else if (!((m_ph == 1 && !car_ew) || (m_ph == 4 && !car_ns))) begin
        case (m_ph)
          0: nxt = m_ped ? 6 : 1;
          1: nxt = 2;
          2: nxt = 3;
          3: nxt = 4;
          4: nxt = 5;
          5: nxt = 0;
          default: nxt = 1;
        endcase
        entered = nxt == 6;
        m_ph = nxt;
        m_cnt = dur(nxt) - 1;
      end
    end
    m_ped = ped_req | (m_ped & !entered);
    #1;
  endtask
  task automatic test_reset();
    reset = 0; tick = 1; car_ns = 1; car_ew = 1;
    #12;
    n_cmp++;
    if ({phase, cnt_q, ns_light, ew_light} !== {3'd0, NB'(0), 6'b100_100}) begin
      n_bad++;
      $display("FAIL reset_state: phase=%0d cnt=%0d ns=%b ew=%b, expected phase=0 cnt=0 ns=100 ew=100", phase, cnt_q, ns_light, ew_light);
    end
    @(negedge clk);
    reset = 1;
    model_reset();
    step();
    n_cmp++;
    if ({phase, cnt_q, ns_light, ew_light} !== {3'd1, NB'(2), 6'b001_100}) begin
      n_bad++;
      $display("FAIL reset_release: phase=%0d cnt=%0d ns=%b ew=%b, expected phase=1 cnt=2 ns=001 ew=100", phase, cnt_q, ns_light, ew_light);
    end
  endtask
  task automatic test_cycle();
    int seq [13] = '{1, 1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0, 1};
    reset = 0; car_ns = 1; car_ew = 1; tick = 1;
    #1;
    n_cmp++;
    if (phase !== 3'd0) begin
      n_bad++;
      $display("FAIL cycle_start: phase=%0d, expected 0", phase);
    end
    reset = 1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if ({phase, cnt_q, ns_light, ew_light} !== model_vec()) begin
        n_bad++;
        $display("FAIL cycle_model[%0d]: phase=%0d cnt=%0d lamps=%b%b, expected phase=%0d cnt=%0d lamps=%b", i, phase, cnt_q, ns_light, ew_light, m_ph, m_cnt, lamps(m_ph));
      end
      if (i < 13) begin
        n_cmp++;
        if (phase !== 3'(seq[i])) begin
          n_bad++;
          $display("FAIL cycle_seq[%0d]: phase=%0d, expected %0d", i, phase, seq[i]);
        end
      end
      n_cmp++;
      if (ns_light == 3'b001 && ew_light == 3'b001) begin
        n_bad++;
        $display("FAIL cycle_both_green[%0d]: ns=%b ew=%b, expected at most one green", i, ns_light, ew_light);
      end
    end
  endtask
  task automatic test_rest();
    int k = 0;
    car_ew = 0; car_ns = 1; tick = 1;
    while (!(m_ph == 1 && m_cnt == 0) && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (k >= 20) begin
      n_bad++;
      $display("FAIL rest_reach: NS_G expiry not reached within 20 cycles, phase=%0d", phase);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({phase, cnt_q} !== {3'd1, NB'(0)}) begin
        n_bad++;
        $display("FAIL rest_hold[%0d]: phase=%0d cnt=%0d, expected phase=1 cnt=0", i, phase, cnt_q);
      end
    end
    car_ew = 1;
    step();
    n_cmp++;
    if ({phase, cnt_q} !== {3'd2, NB'(1)}) begin
      n_bad++;
      $display("FAIL rest_leave: phase=%0d cnt=%0d, expected phase=2 cnt=1", phase, cnt_q);
    end
  endtask
  task automatic test_tick_gap();
    logic [2:0] p_ph;
    logic [NB-1:0] p_cnt;
    for (int i = 0; i < 64; i++) begin
      tick = (i % 4) == 3;
      car_ns = $urandom_range(0, 3) != 0;
      car_ew = $urandom_range(0, 3) != 0;
      p_ph = phase; p_cnt = cnt_q;
      step();
      n_cmp++;
      if ({phase, cnt_q, ns_light, ew_light} !== model_vec()) begin
        n_bad++;
        $display("FAIL tick_model[%0d]: phase=%0d cnt=%0d lamps=%b%b, expected phase=%0d cnt=%0d lamps=%b", i, phase, cnt_q, ns_light, ew_light, m_ph, m_cnt, lamps(m_ph));
      end
      if (!tick) begin
        n_cmp++;
        if ({phase, cnt_q} !== {p_ph, p_cnt}) begin
          n_bad++;
          $display("FAIL tick_hold[%0d]: phase=%0d cnt=%0d, expected phase=%0d cnt=%0d", i, phase, cnt_q, p_ph, p_cnt);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick = $urandom_range(0, 1);
      car_ns = $urandom_range(0, 2) != 0;
      car_ew = $urandom_range(0, 2) != 0;
      step();
      n_cmp++;
      if ({phase, cnt_q, ns_light, ew_light} !== model_vec()) begin
        n_bad++;
        $display("FAIL random_model[%0d]: phase=%0d cnt=%0d lamps=%b%b, expected phase=%0d cnt=%0d lamps=%b", i, phase, cnt_q, ns_light, ew_light, m_ph, m_cnt, lamps(m_ph));
      end
      n_cmp++;
      if (ns_light == 3'b001 && ew_light == 3'b001) begin
        n_bad++;
        $display("FAIL random_both_green[%0d]: ns=%b ew=%b, expected at most one green", i, ns_light, ew_light);
      end
    end
  endtask
  task automatic test_async_reset();
    int k = 0;
    tick = 1; car_ns = 1; car_ew = 1;
    while (m_ph != 4 && k < 30) begin
      step();
      k++;
    end
    n_cmp++;
    if (phase !== 3'd4) begin
      n_bad++;
      $display("FAIL areset_reach: phase=%0d, expected 4 within 30 cycles", phase);
    end
    #3;
    reset = 0;
    #1;
    n_cmp++;
    if ({phase, cnt_q, ns_light, ew_light} !== {3'd0, NB'(0), 6'b100_100}) begin
      n_bad++;
      $display("FAIL areset_immediate: phase=%0d cnt=%0d ns=%b ew=%b, expected phase=0 cnt=0 ns=100 ew=100", phase, cnt_q, ns_light, ew_light);
    end
`ifdef TRAFFIC_PED_WALK_EN
    n_cmp++;
    if (walk !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_walk: walk=%b, expected 0", walk);
    end
`endif
    #2;
    reset = 1;
    model_reset();
    step();
    n_cmp++;
    if ({phase, cnt_q, ns_light, ew_light} !== model_vec()) begin
      n_bad++;
      $display("FAIL areset_resume: phase=%0d cnt=%0d, expected phase=%0d cnt=%0d", phase, cnt_q, m_ph, m_cnt);
    end
  endtask
`ifdef TRAFFIC_PED_WALK_EN
  task automatic test_walk();
    int k = 0, walk_cycles = 0;
    bit seen = 0;
    tick = 1; car_ns = 1; car_ew = 1;
    while (m_ph != 1 && k < 20) begin
      step();
      k++;
    end
    ped_req = 1;
    step();
    ped_req = 0;
    k = 0;
    while (!(seen && m_ph == 1) && k < 40) begin
      step();
      k++;
      if (m_ph == 6) seen = 1;
      if (walk === 1'b1 && phase == 3'd6) walk_cycles++;
      n_cmp++;
      if ({phase, cnt_q, ns_light, ew_light, walk} !== {model_vec(), m_ph == 6}) begin
        n_bad++;
        $display("FAIL walk_model[%0d]: phase=%0d cnt=%0d walk=%b, expected phase=%0d cnt=%0d walk=%0d", k, phase, cnt_q, walk, m_ph, m_cnt, m_ph == 6);
      end
    end
    n_cmp++;
    if (walk_cycles != 2 || phase !== 3'd1) begin
      n_bad++;
      $display("FAIL walk_span: walk cycles=%0d final phase=%0d, expected 2 cycles then phase 1", walk_cycles, phase);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_cycle();
    test_rest();
    test_tick_gap();
    test_random();
    test_async_reset();
`ifdef TRAFFIC_PED_WALK_EN
    test_walk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
